// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and constants for the two-master on-chip RAM arbiter.
package onchip_mem_arb_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_t;

  localparam int          RUN_W        = 4;
  localparam logic [31:0] OOR_READDATA = 32'h0;

  function automatic master_t other_master(input master_t m);
    return (m == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant with a bounded run length for the current holder.
module rr_grant2
  import onchip_mem_arb_pkg::*;
#(
  parameter int MAX_RUN = 4
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    req0,
  input  logic    req1,
  output master_t winner,
  output logic    grant_valid
);

  master_t          last_grant;
  logic [RUN_W-1:0] run_cnt;
  logic             holder_keeps;

  // A zero run count means nobody currently holds a run (after reset or an
  // idle cycle), so contention goes to the master opposite last_grant.
  assign holder_keeps = (run_cnt != '0) && (run_cnt < RUN_W'(MAX_RUN));
  assign grant_valid  = req0 | req1;

  always_comb begin
    // NOTE: winner gets a value on every path before any branch, so no latch is inferred.
    winner = M0;
    if (req0 && req1) begin
      winner = holder_keeps ? last_grant : other_master(last_grant);
    end else if (req1) begin
      winner = M1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= M1;
      run_cnt    <= '0;
    end else if (grant_valid) begin
      last_grant <= winner;
      if (winner == last_grant) begin
        run_cnt <= (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
      end else begin
        run_cnt <= RUN_W'(1);
      end
    end else begin
      run_cnt <= '0;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port 32-bit RAM (1-cycle read latency) between two Avalon-MM masters.
// Define AUDIOVIS_MEM_ARB_STATS_EN to add per-master grant and stall counters.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int DEPTH   = 23719,
  parameter int MAX_RUN = 4,
  parameter int ADDR_W  = 15
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
`ifdef AUDIOVIS_MEM_ARB_STATS_EN
  input  logic              stat_clear,
  output logic [31:0]       stat_m0_grants,
  output logic [31:0]       stat_m1_grants,
  output logic [31:0]       stat_m0_stalls,
  output logic [31:0]       stat_m1_stalls,
`endif
  input  logic [31:0]       mem_readdata
);

  logic        req0, req1, grant_valid, accept, in_range, sel_write;
  logic        rd_pending, rd_oor;
  master_t     winner, rd_owner;
  logic [31:0] ret_data, hold0, hold1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  rr_grant2 #(
    .MAX_RUN(MAX_RUN)
  ) u_grant (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0       (req0),
    .req1       (req1),
    .winner     (winner),
    .grant_valid(grant_valid)
  );

  assign accept = grant_valid & reset_n;

  assign m0_waitrequest = ~reset_n | (req0 & ~(accept & (winner == M0)));
  assign m1_waitrequest = ~reset_n | (req1 & ~(accept & (winner == M1)));

  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    sel_write      = m0_write;
    if (winner == M1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      sel_write      = m1_write;
    end
  end

  // Out-of-range words are never selected, so such writes vanish and reads
  // still complete through the return pipeline with zero data.
  assign in_range       = 32'(mem_address) < 32'(DEPTH);
  assign mem_chipselect = accept & in_range;
  assign mem_write      = accept & sel_write;
  assign mem_clken      = reset_n;

  assign ret_data         = rd_oor ? OOR_READDATA : mem_readdata;
  assign m0_readdatavalid = rd_pending & (rd_owner == M0);
  assign m1_readdatavalid = rd_pending & (rd_owner == M1);
  assign m0_readdata      = m0_readdatavalid ? ret_data : hold0;
  assign m1_readdata      = m1_readdatavalid ? ret_data : hold1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending <= 1'b0;
      rd_owner   <= M0;
      rd_oor     <= 1'b0;
      hold0      <= '0;
      hold1      <= '0;
    end else begin
      rd_pending <= accept & ~sel_write;
      rd_owner   <= winner;
      rd_oor     <= ~in_range;
      if (m0_readdatavalid) hold0 <= ret_data;
      if (m1_readdatavalid) hold1 <= ret_data;
    end
  end

`ifdef AUDIOVIS_MEM_ARB_STATS_EN
  // Clear takes priority over any increment landing in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_m0_grants <= '0;
      stat_m1_grants <= '0;
      stat_m0_stalls <= '0;
      stat_m1_stalls <= '0;
    end else if (stat_clear) begin
      stat_m0_grants <= '0;
      stat_m1_grants <= '0;
      stat_m0_stalls <= '0;
      stat_m1_stalls <= '0;
    end else begin
      if (accept && (winner == M0)) stat_m0_grants <= stat_m0_grants + 32'd1;
      if (accept && (winner == M1)) stat_m1_grants <= stat_m1_grants + 32'd1;
      if (m0_waitrequest)           stat_m0_stalls <= stat_m0_stalls + 32'd1;
      if (m1_waitrequest)           stat_m1_stalls <= stat_m1_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Randomized and directed bench for onchip_mem_arbiter against a behavioural arbitration/memory model.
module tb_onchip_mem_arbiter;

  localparam int DEPTH   = 23719;
  localparam int MAX_RUN = 4;
  localparam int ADDR_W  = 15;

  logic clk = 1'b0;
  logic reset_n;

  logic              rd[2], wr[2];
  logic [ADDR_W-1:0] addr[2];
  logic [3:0]        be[2];
  logic [31:0]       wd[2];
  logic              waitreq[2], rdv[2];
  logic [31:0]       rdata[2];

  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata = '0;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] ram[DEPTH];
  logic [31:0] exp_mem[DEPTH];

  // Reference model state: who last won, length of its current streak,
  // the read expected back next cycle, and each master's held read data.
  int          last_win, streak, pend_owner;
  bit          pend_v;
  logic [31:0] pend_data;
  logic [31:0] hold[2];

  always #5 clk = ~clk;

  onchip_mem_arbiter #(
    .DEPTH  (DEPTH),
    .MAX_RUN(MAX_RUN),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .m0_address      (addr[0]),
    .m0_byteenable   (be[0]),
    .m0_read         (rd[0]),
    .m0_write        (wr[0]),
    .m0_writedata    (wd[0]),
    .m0_waitrequest  (waitreq[0]),
    .m0_readdata     (rdata[0]),
    .m0_readdatavalid(rdv[0]),
    .m1_address      (addr[1]),
    .m1_byteenable   (be[1]),
    .m1_read         (rd[1]),
    .m1_write        (wr[1]),
    .m1_writedata    (wd[1]),
    .m1_waitrequest  (waitreq[1]),
    .m1_readdata     (rdata[1]),
    .m1_readdatavalid(rdv[1]),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_clken       (mem_clken),
    .mem_readdata    (mem_readdata)
  );

  // Single-port RAM with byte enables and one cycle of read latency.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect && int'(mem_address) < DEPTH) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] lanes);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (lanes[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic set_m(input int m, input bit r, input bit w, input int a,
                       input logic [3:0] lanes, input logic [31:0] d);
    rd[m]   = r;
    wr[m]   = w;
    addr[m] = ADDR_W'(a);
    be[m]   = lanes;
    wd[m]   = d;
  endtask

  task automatic idle();
    set_m(0, 0, 0, 0, 4'h0, 32'h0);
    set_m(1, 0, 0, 0, 4'h0, 32'h0);
  endtask

  // Compare one cycle of DUT behaviour against the model, then advance the model.
  task automatic eval_cycle();
    bit          req[2];
    bit          any, inr, is_wr, v;
    int          win, a;
    for (int m = 0; m < 2; m++) begin
      v = pend_v && (pend_owner == m);
      check($sformatf("m%0d_readdatavalid", m), 32'(rdv[m]), 32'(v));
      if (v) hold[m] = pend_data;
      check($sformatf("m%0d_readdata", m), rdata[m], hold[m]);
      req[m] = rd[m] | wr[m];
    end
    any = req[0] | req[1];
    if (req[0] && req[1]) win = (streak > 0 && streak < MAX_RUN) ? last_win : 1 - last_win;
    else                  win = req[1] ? 1 : 0;
    for (int m = 0; m < 2; m++)
      check($sformatf("m%0d_waitrequest", m), 32'(waitreq[m]), 32'(req[m] && win != m));
    a     = int'(addr[win]);
    inr   = a < DEPTH;
    is_wr = wr[win];
    check("mem_clken", 32'(mem_clken), 32'(1));
    check("mem_chipselect", 32'(mem_chipselect), 32'(any && inr));
    check("mem_write", 32'(mem_write), 32'(any && is_wr));
    if (any) begin
      check("mem_address", 32'(mem_address), 32'(a));
      if (is_wr && inr) begin
        check("mem_byteenable", 32'(mem_byteenable), 32'(be[win]));
        check("mem_writedata", mem_writedata, wd[win]);
      end
    end
    pend_v     = any && !is_wr;
    pend_owner = win;
    pend_data  = inr ? exp_mem[a] : 32'h0;
    if (any && is_wr && inr) exp_mem[a] = merge(exp_mem[a], wd[win], be[win]);
    if (!any) begin
      streak = 0;
    end else begin
      streak   = (win == last_win) ? ((streak < 15) ? streak + 1 : 15) : 1;
      last_win = win;
    end
  endtask

  task automatic step();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two cycles with both masters requesting, checking the idle outputs.
  task automatic do_reset();
    set_m(0, 1, 1, 'h300, 4'hF, 32'hFFFF_FFFF);
    set_m(1, 1, 0, 'h301, 4'hF, 32'h0);
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        check($sformatf("rst_m%0d_waitrequest", m), 32'(waitreq[m]), 32'(1));
        check($sformatf("rst_m%0d_readdatavalid", m), 32'(rdv[m]), 32'(0));
        check($sformatf("rst_m%0d_readdata", m), rdata[m], 32'h0);
      end
      check("rst_mem_chipselect", 32'(mem_chipselect), 32'(0));
      check("rst_mem_write", 32'(mem_write), 32'(0));
      check("rst_mem_clken", 32'(mem_clken), 32'(0));
      @(posedge clk);
      #1;
    end
    idle();
    last_win = 1;
    streak   = 0;
    pend_v   = 0;
    hold[0]  = '0;
    hold[1]  = '0;
    reset_n  = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = '0;
      exp_mem[i] = '0;
    end
    reset_n = 1'b1;
    idle();
    #2;
    do_reset();

    // Both masters write continuously straight out of reset.
    for (int i = 0; i < 12; i++) begin
      set_m(0, 0, 1, 'h200 + i, 4'hF, 32'h1000 + i);
      set_m(1, 0, 1, 'h280 + i, 4'hF, 32'h2000 + i);
      @(negedge clk);
      check("burst_m1_wins", 32'(waitreq[0]), 32'((i / 4) % 2));
      eval_cycle();
      @(posedge clk);
      #1;
    end

    // Single-master read of a known word.
    idle(); set_m(0, 0, 1, 'h10, 4'hF, 32'hDEAD_BEEF); step();
    idle(); set_m(0, 1, 0, 'h10, 4'h0, 32'h0);         step();
    idle(); step();
    check("read_deadbeef", rdata[0], 32'hDEAD_BEEF);

    // Partial-lane write by m1, read back by m0.
    idle(); set_m(1, 0, 1, 'h100, 4'b0101, 32'hAABB_CCDD); step();
    idle(); set_m(0, 1, 0, 'h100, 4'h0, 32'h0);            step();
    idle(); step();
    check("byteenable_merge", rdata[0], 32'h00BB_00DD);

    // Out-of-range write is dropped; out-of-range read returns zero.
    idle(); set_m(0, 0, 1, DEPTH, 4'hF, 32'h1234_5678); step();
    idle(); set_m(0, 1, 0, DEPTH, 4'h0, 32'h0);         step();
    idle(); step();
    check("oor_read_zero", rdata[0], 32'h0);

    // Back-to-back reads alternating owners.
    for (int i = 1; i <= 3; i++) begin
      idle(); set_m(0, 0, 1, i, 4'hF, 32'h5A00_0000 + i); step();
    end
    idle(); set_m(0, 1, 0, 1, 4'h0, 32'h0); step();
    idle(); set_m(1, 1, 0, 2, 4'h0, 32'h0); step();
    idle(); set_m(0, 1, 0, 3, 4'h0, 32'h0); step();
    idle(); step();
    check("b2b_m0_last", rdata[0], 32'h5A00_0003);
    check("b2b_m1_last", rdata[1], 32'h5A00_0002);

    // Reset lands the cycle after a read is accepted.
    idle(); set_m(0, 0, 1, 5, 4'hF, 32'hC0FF_EE00); step();
    idle(); set_m(0, 1, 0, 5, 4'h0, 32'h0); step();
    do_reset();
    idle(); step();
    set_m(0, 0, 1, 6, 4'hF, 32'h6);
    set_m(1, 0, 1, 7, 4'hF, 32'h7);
    @(negedge clk);
    check("post_reset_m0_first", 32'(waitreq[1]), 32'(1));
    eval_cycle();
    @(posedge clk);
    #1;

    // Random traffic including out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        int kind, a;
        kind = $urandom_range(0, 3);
        a    = ($urandom_range(0, 9) == 0) ? DEPTH - 3 + $urandom_range(0, 6)
                                           : $urandom_range(0, 31);
        set_m(m, kind[0], kind[1], a, 4'($urandom), $urandom);
      end
      step();
    end
    idle(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
Shares the single-port 32-bit on-chip RAM (DEPTH words, 15-bit word address, byte enables, 1-cycle read latency) between two Avalon-MM masters. m0 is the Nios data port and m1 is the audio sample/FFT buffer writer. The block arbitrates round-robin with a bounded run length, drives the RAM's chipselect/write/clken, and returns read data with readdatavalid. It sits between the interconnect and the RAM instance.

Parameters:
DEPTH, 23719, number of implemented 32-bit words; word addresses >= DEPTH are out of range.
MAX_RUN, 4, maximum consecutive grants to one master while the other master is requesting (1..15).
ADDR_W, 15, word address width.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  master 0 word address
m0_byteenable  in  4  master 0 byte lanes
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  32  master 0 write data
m0_waitrequest  out  1  master 0 stall
m0_readdata  out  32  master 0 read data
m0_readdatavalid  out  1  master 0 read data valid
m1_*  same set as m0_*, for master 1
mem_address  out  ADDR_W  RAM address
mem_byteenable  out  4  RAM byte enables
mem_chipselect  out  1  RAM select
mem_write  out  1  RAM write strobe
mem_writedata  out  32  RAM write data
mem_clken  out  1  RAM clock enable
mem_readdata  in  32  RAM output, valid the cycle after the read is issued

Behaviour:
- Reset (reset_n low, asynchronous): m*_waitrequest=1, m*_readdatavalid=0, m*_readdata=0, mem_chipselect=0, mem_write=0, last_grant=1 (m0 wins first), run_cnt=0, rd_pending=0. mem_clken is 1 except during reset.
- Request: mN_req = mN_read | mN_write. If read and write are both high, treat as a write.
- Grant decision is combinational each cycle:
  - Only one master requesting: that master wins.
  - Both requesting: the master opposite last_grant wins, unless run_cnt < MAX_RUN and the holder is still requesting; then the holder keeps the grant.
- mN_waitrequest = mN_req & ~grantN. The winner is accepted in that cycle. Non-requesting masters see waitrequest=0.
- Accepted access drives, combinationally in the same cycle:
  - mem_address/byteenable/writedata from the winner.
  - mem_chipselect=1.
  - mem_write = winner write.
- Out-of-range address (>= DEPTH):
  - mem_chipselect=0, so the write is dropped.
  - A read is still accepted; its data returns as 32'h0 with readdatavalid.
- Registers on acceptance:
  - last_grant <= winner.
  - run_cnt <= (winner == previous holder) ? saturating run_cnt+1 : 1.
  - With no request in the cycle, run_cnt <= 0.
- Read return is a fixed 1-cycle pipeline:
  - rd_pending/rd_owner/rd_oor are registered on accept.
  - In the next cycle, m{rd_owner}_readdatavalid=1 and m{rd_owner}_readdata = rd_oor ? 0 : mem_readdata.
  - A new access may be accepted in that same cycle (full throughput, one access per cycle).
  - readdata is held between valids; the other master's readdatavalid stays 0.
- No read/write hazard: accesses are serialised and the RAM's write completes before any later read.
- Reset mid-read: the pending readdatavalid is discarded and not returned after reset.

Optional Feature:
AUDIOVIS_MEM_ARB_STATS_EN:
- When defined, adds outputs stat_m0_grants, stat_m1_grants, stat_m0_stalls, stat_m1_stalls (32-bit each) and input stat_clear.
- Grant counters increment per accepted access. Stall counters increment per cycle with mN_waitrequest=1 after reset. All counters wrap at 2^32.
- stat_clear=1 zeroes all counters synchronously; clear wins over a simultaneous increment. Counters reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package onchip_mem_arb_pkg: master index typedef (M0=0, M1=1), RUN_W=4, OOR_READDATA=32'h0.
- One sub-module rr_grant2: the 2-way round-robin decision with run-length counter, exposing winner and grant_valid.

Test Plan:
- m0 reads addr 0x0010 with RAM word 0xDEADBEEF -> m0_waitrequest=0 in the request cycle; m0_readdatavalid=1 and m0_readdata=0xDEADBEEF in the next cycle; m1 signals unchanged.
- Both masters write continuously from reset with MAX_RUN=4 -> grants in order m0 x4, m1 x4, m0 x4; the losing master's waitrequest=1 on each lost cycle.
- m1 writes 0xAABBCCDD with byteenable 4'b0101 to 0x0100, then m0 reads 0x0100 (old value 0) -> m0_readdata=0x00BB00DD.
- m0 writes to 23719 and then reads 23719 -> mem_chipselect=0 on both; read returns 0x0 with readdatavalid; RAM contents unchanged.
- Back-to-back reads m0@1, m1@2, m0@3 with only one request per cycle -> three consecutive readdatavalids, each routed to the correct master.
- reset_n asserted the cycle after a read is accepted -> no readdatavalid after release; waitrequest=1 during reset; the first grant after reset goes to m0 when both request.
